// File: rtl/jesd207_pair_fifo.sv
// Single-clock I/Q pair FIFO with registered flags, sticky error flags and
// optional peak-occupancy watermark (enable with JESD_FIFO_WATERMARK_EN).
module jesd207_pair_fifo #(
   parameter int DATA_WID      = 12,
   parameter int ADDR_WID      = 7,
   parameter int PROG_FULL_TH  = 96,
   parameter int PROG_EMPTY_TH = 16
) (
   input  logic                  mclk,
   input  logic                  rstn,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [2*DATA_WID-1:0] wdata,
   input  logic                  rd_en,
   output logic [2*DATA_WID-1:0] rdata,
   output logic                  rvalid,
   output logic                  wfull,
   output logic                  rempty,
   output logic                  prog_full,
   output logic                  prog_empty,
   output logic [ADDR_WID:0]     count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err,
   output logic [ADDR_WID:0]     max_count
);

   localparam int CW = ADDR_WID + 1;
   localparam int DEPTH = 2**ADDR_WID;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] PF_TH_C = CW'(PROG_FULL_TH);
   localparam logic [CW-1:0] PE_TH_C = CW'(PROG_EMPTY_TH);

   logic [2*DATA_WID-1:0] mem [DEPTH];
   logic [ADDR_WID-1:0]   wptr, rptr;
   logic [CW-1:0]         count_nxt;
   logic                  wr_acc, rd_acc, ovf_set, unf_set;

   // Acceptance uses the registered flags, so a full FIFO reads but never
   // writes on a simultaneous request, and an empty one the reverse.
   assign wr_acc  = wr_en & ~wfull  & ~flush;
   assign rd_acc  = rd_en & ~rempty & ~flush;
   assign ovf_set = wr_en &  wfull  & ~flush;
   assign unf_set = rd_en &  rempty & ~flush;

   always_comb begin
      count_nxt = count;
      if (flush)
         count_nxt = '0;
      else if (wr_acc && !rd_acc)
         count_nxt = count + CW'(1);
      else if (rd_acc && !wr_acc)
         count_nxt = count - CW'(1);
   end

   always_ff @(posedge mclk) begin
      if (wr_acc)
         mem[wptr] <= wdata;
   end

   always_ff @(posedge mclk or negedge rstn) begin
      if (!rstn) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         rdata      <= '0;
         rvalid     <= 1'b0;
         wfull      <= 1'b0;
         rempty     <= 1'b1;
         prog_full  <= 1'b0;
         prog_empty <= 1'b1;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (flush) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (wr_acc)
               wptr <= wptr + ADDR_WID'(1);
            if (rd_acc) begin
               rptr  <= rptr + ADDR_WID'(1);
               rdata <= mem[rptr];
            end
         end
         rvalid     <= rd_acc;
         count      <= count_nxt;
         wfull      <= (count_nxt == DEPTH_C);
         rempty     <= (count_nxt == '0);
         prog_full  <= (count_nxt >= PF_TH_C);
         prog_empty <= (count_nxt <= PE_TH_C);
         overflow   <= ovf_set | (overflow  & ~clr_err);
         underflow  <= unf_set | (underflow & ~clr_err);
      end
   end

`ifdef JESD_FIFO_WATERMARK_EN
   logic [CW-1:0] max_q;

   // Watermark trails count by one cycle; clr_err rebases it to the live level.
   always_ff @(posedge mclk or negedge rstn) begin
      if (!rstn)
         max_q <= '0;
      else if (flush)
         max_q <= '0;
      else if (clr_err)
         max_q <= count;
      else if (count > max_q)
         max_q <= count;
   end

   assign max_count = max_q;
`else
   assign max_count = '0;
`endif

endmodule

// File: tb/tb_jesd207_pair_fifo.sv
// Self-checking bench for jesd207_pair_fifo: queue-based reference FIFO plus
// an expected-read scoreboard, all outputs compared every cycle.
module tb_jesd207_pair_fifo;

   logic        mclk = 1'b0;
   logic        rstn;
   logic        flush, wr_en, rd_en, clr_err;
   logic [23:0] wdata;
   logic [23:0] rdata;
   logic        rvalid, wfull, rempty, prog_full, prog_empty;
   logic [7:0]  count, max_count;
   logic        overflow, underflow;

   int total = 0;
   int bad   = 0;

   logic [23:0] model_q[$];
   logic [23:0] exp_q[$];
   logic        m_ovf, m_unf;
   int          m_max;
   logic [23:0] seq;

   jesd207_pair_fifo dut (
      .mclk       (mclk),
      .rstn       (rstn),
      .flush      (flush),
      .wr_en      (wr_en),
      .wdata      (wdata),
      .rd_en      (rd_en),
      .rdata      (rdata),
      .rvalid     (rvalid),
      .wfull      (wfull),
      .rempty     (rempty),
      .prog_full  (prog_full),
      .prog_empty (prog_empty),
      .count      (count),
      .overflow   (overflow),
      .underflow  (underflow),
      .clr_err    (clr_err),
      .max_count  (max_count)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_max();
`ifdef JESD_FIFO_WATERMARK_EN
      return m_max;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      model_q.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_max = 0;
   endtask

   task automatic chk_state(input logic exp_rv);
      int sz;
      sz = model_q.size();
      chk("count",      32'(count),      32'(sz));
      chk("wfull",      32'(wfull),      32'(sz == 128));
      chk("rempty",     32'(rempty),     32'(sz == 0));
      chk("prog_full",  32'(prog_full),  32'(sz >= 96));
      chk("prog_empty", 32'(prog_empty), 32'(sz <= 16));
      chk("overflow",   32'(overflow),   32'(m_ovf));
      chk("underflow",  32'(underflow),  32'(m_unf));
      chk("max_count",  32'(max_count),  32'(exp_max()));
      chk("rvalid",     32'(rvalid),     32'(exp_rv));
   endtask

   // One clock with the given request pattern; the model advances alongside.
   task automatic cyc(input logic w, input logic r, input logic fl, input logic ce,
                      input logic [23:0] d);
      int sz;
      logic mfull, mempty, wacc, racc;
      logic [23:0] v;
      sz = model_q.size();
      mfull  = (sz == 128);
      mempty = (sz == 0);
      wacc = w & ~mfull  & ~fl;
      racc = r & ~mempty & ~fl;
      wr_en = w; rd_en = r; flush = fl; clr_err = ce; wdata = d;
      m_ovf = (w & mfull  & ~fl) | (m_ovf & ~ce);
      m_unf = (r & mempty & ~fl) | (m_unf & ~ce);
      if (fl)               m_max = 0;
      else if (ce)          m_max = sz;
      else if (sz > m_max)  m_max = sz;
      if (racc) exp_q.push_back(model_q.pop_front());
      if (wacc) model_q.push_back(d);
      if (fl)   model_q.delete();
      @(posedge mclk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
      chk_state(racc);
      if (racc) begin
         v = exp_q.pop_front();
         chk("rdata", 32'(rdata), 32'(v));
      end
   endtask

   task automatic wr_n(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0, seq);
         seq = seq + 24'h001001;
      end
   endtask

   task automatic rd_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
   endtask

   initial begin
      rstn = 1'b0;
      flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wdata = '0;
      model_reset();
      repeat (2) @(posedge mclk);
      #1;
      chk("rst_rdata", 32'(rdata), 32'h0);
      chk_state(1'b0);
      rstn = 1'b1;
      @(posedge mclk);
      #1;

      // fill 0x001001..0x080080, then one over
      seq = 24'h001001;
      wr_n(128);
      chk("full_count", 32'(count), 32'd128);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'hFFFFFF);
      chk("ovf_129", 32'(overflow), 32'd1);

      // drain in order, then one extra read
      rd_n(128);
      chk("empty_after", 32'(rempty), 32'd1);
      rd_n(1);
      chk("unf_extra", 32'(underflow), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);

      // steady state at 64 with pointer wrap
      wr_n(64);
      for (int i = 0; i < 300; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0, seq);
         seq = seq + 24'h000101;
      end
      chk("steady_count", 32'(count), 32'd64);
      rd_n(64);

      // simultaneous requests at the two extremes
      wr_n(128);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 24'h123456);
      chk("full_rw_count", 32'(count), 32'd127);
      rd_n(127);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 24'h654321);
      chk("empty_rw_count", 32'(count), 32'd1);
      chk("empty_rw_rvalid", 32'(rvalid), 32'd0);
      rd_n(1);

      // flush keeps sticky flags; clr_err loses to a new overflow
      wr_n(50);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 24'hAAAAAA);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_ovf", 32'(overflow), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
      wr_n(128);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 24'hBBBBBB);
      chk("clr_vs_ovf", 32'(overflow), 32'd1);

      // watermark: fill 100, drain 90, then rebase
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 24'h0);
      wr_n(100);
      rd_n(90);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);

      // asynchronous reset mid-burst
      wr_n(20);
      wr_en = 1'b1; wdata = 24'h777777;
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      chk("arst_rdata", 32'(rdata), 32'h0);
      chk_state(1'b0);
      @(posedge mclk);
      #1;
      wr_en = 1'b0;
      rstn = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'hABCDEF);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h135791);
      rd_n(2);
      chk("post_rst_empty", 32'(rempty), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
